uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- UART receiver controller: receive side of the team's UART; decodes frames produced by the UART transmit FSM/serializer.
- Oversamples rx_in by a runtime prescale and takes a 3-sample majority vote at mid-bit.
- Checks start, optional parity (even/odd) and stop bits, deserializes LSB-first data and presents one parallel byte per good frame with a single-cycle valid pulse.
- Sits between the pad-side synchronizer and the system RX FIFO/register file.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the prescale input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  serial line, already synchronized to clk; idles high.
- prescale  input  PRESCALE_W  clk cycles per bit; even values 8..62 supported.
- par_en  input  1  1 = parity bit present after data.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- p_data  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse when p_data updates.
- par_err  output  1  one-cycle pulse on a parity mismatch.
- stp_err  output  1  one-cycle pulse on a stop bit sampled low.
- busy  output  1  high while a frame is in progress (START..STOP).

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0: p_data=0, data_valid=0, par_err=0, stp_err=0, busy=0.
  - State goes to IDLE; edge_cnt, bit_cnt and the shift register clear.
  - Reset mid-frame aborts the frame with no pulse.
- Config latch: prescale, par_en and par_typ are captured on the IDLE->START transition and held for the whole frame. Changes mid-frame have no effect.
- Edge counter:
  - edge_cnt runs 0..P-1 in each bit period, where P is the latched prescale.
  - Wraps to 0 at P-1 and increments bit_cnt.
- Sampling:
  - rx_in is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, decided at edge_cnt = P/2+2.
- States:
  - IDLE: busy=0. rx_in==0 -> START; edge_cnt=0 on the first START cycle. The detection cycle itself is not counted.
  - START: at edge P-1, voted bit 0 -> DATA; voted bit 1 (glitch) -> IDLE with no output pulse.
  - DATA: the voted bit shifts in LSB first. After DATA_WIDTH bits, at edge P-1: par_en=1 -> PARITY, else -> STOP.
  - PARITY: expected bit = XOR(data) ^ par_typ. Mismatch sets an internal parity flag. At edge P-1 -> STOP.
  - STOP: expected bit is 1. At edge P-1 -> IDLE.
- End-of-frame outputs, registered, in the cycle after the STOP final edge:
  - Parity flag clear and stop bit 1: p_data <= shift register, data_valid=1.
  - Parity flag set: par_err=1 and p_data is unchanged.
  - Stop bit 0: stp_err=1 and p_data is unchanged.
  - Both errors can pulse in the same cycle; data_valid never pulses together with either error.
  - All pulses last exactly 1 cycle. p_data holds between frames.
- Back-to-back frames: IDLE may detect a new start bit in the first cycle after STOP. No idle gap is required beyond the stop bit.
- Stop bit low followed by continued low: the frame is reported as stp_err. IDLE then sees rx_in=0 and begins a new frame; this is the defined behaviour, with no break detection.
- busy is 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Latency example: prescale=8, no parity, start detected at cycle T. STOP final edge is at T+80 and data_valid is at T+81.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, rx_in=1 for 100 cycles -> all outputs 0, busy=0 throughout.
- Good frame: prescale=8, par_en=0, send 0xA5 (start, LSB first, stop). Expect data_valid exactly at T+81 with p_data=0xA5, no error pulse, busy high T+1..T+80.
- Parity and prescale: prescale=16, par_en=1, par_typ=0, send 0x3C with parity 0 -> data_valid, p_data=0x3C. Repeat with par_typ=1 and the same parity bit 0 -> par_err pulse, p_data stays 0x3C.
- Line errors:
  - Stop bit driven 0 for 0x55 -> stp_err pulse, no data_valid.
  - Start glitch: rx_in low for 2 cycles at prescale=8 -> return to IDLE, no pulses.
  - Single-cycle low noise inside a data bit at sample P/2 -> majority keeps the correct bit.
- Back-to-back and reset mid-frame:
  - Two frames 0x01 then 0xFE with no idle gap at prescale=32 -> two data_valid pulses with the correct values.
  - rst asserted during bit 4 -> busy=0 next cycle, no pulse. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receive bundle: serial line and frame config in, decoded word and
// status pulses out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output rx_in,
    output prescale,
    output par_en,
    output par_typ,
    input  p_data,
    input  data_valid,
    input  par_err,
    input  stp_err,
    input  busy
  );

  modport slave (
    input  rx_in,
    input  prescale,
    input  par_en,
    input  par_typ,
    output p_data,
    output data_valid,
    output par_err,
    output stp_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled 3-way majority vote, LSB-first deserializer,
// optional parity and stop checks, one-cycle result pulses.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;

  logic [PRESCALE_W-1:0] p_lat;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic [2:0]            smp;
  logic                  pe_lat;
  logic                  pt_lat;
  logic                  par_flag;
  logic                  bit_v;
  logic                  dv_q;
  logic                  pe_q;
  logic                  se_q;
  logic                  busy_q;

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] s_lo;
  logic [PRESCALE_W-1:0] s_hi;
  logic [PRESCALE_W-1:0] s_dec;
  logic [PRESCALE_W-1:0] last;
  logic                  at_last;
  logic                  vote;
  logic                  exp_par;

  always_comb begin
    half    = {1'b0, p_lat[PRESCALE_W-1:1]};
    s_lo    = half - ONE;
    s_hi    = half + ONE;
    s_dec   = half + TWO;
    last    = p_lat - ONE;
    at_last = (edge_cnt == last);
    vote    = (smp[0] & smp[1]) |
              (smp[0] & smp[2]) |
              (smp[1] & smp[2]);
    exp_par = (^shreg) ^ pt_lat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      p_lat    <= '0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      p_data_q <= '0;
      smp      <= '0;
      pe_lat   <= 1'b0;
      pt_lat   <= 1'b0;
      par_flag <= 1'b0;
      bit_v    <= 1'b0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      se_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;

      // Bit-period timing and mid-bit sampling shared by all frame states
      if (state != IDLE) begin
        edge_cnt <= at_last ? '0 : edge_cnt + ONE;
        if (edge_cnt == s_lo) smp[0] <= bus.rx_in;
        if (edge_cnt == half) smp[1] <= bus.rx_in;
        if (edge_cnt == s_hi) smp[2] <= bus.rx_in;
        if (edge_cnt == s_dec) bit_v <= vote;
      end

      unique case (state)
        IDLE: begin
          if (!bus.rx_in) begin
            state    <= START;
            busy_q   <= 1'b1;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            p_lat    <= bus.prescale;
            pe_lat   <= bus.par_en;
            pt_lat   <= bus.par_typ;
            par_flag <= 1'b0;
          end
        end
        START: begin
          if (at_last) begin
            if (bit_v) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (at_last) begin
            shreg <= {bit_v, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= pe_lat ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
            end
          end
        end
        PARITY: begin
          if (at_last) begin
            par_flag <= (bit_v != exp_par);
            state    <= STOP;
          end
        end
        STOP: begin
          if (at_last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            pe_q   <= par_flag;
            se_q   <= ~bit_v;
            if (!par_flag && bit_v) begin
              p_data_q <= shreg;
              dv_q     <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.stp_err    = se_q;
  assign bus.busy       = busy_q;

endmodule
